// File: rtl/mux_nx1_stream.sv
// N_CH:1 stream multiplexer with a registered output stage.
// Fixed-select or round-robin grant; full-throughput valid/ready.
module mux_nx1_stream #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  grant;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0] rr_ptr;
  logic             load_en;
  logic             xfer;
  int               c;

  // Grant: sel in fixed mode, first valid from rr_ptr upward otherwise.
  // The RR search runs backwards so the lowest offset wins by overwrite.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    if (!mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          grant[k] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = SEL_W'(k);
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        c = int'(rr_ptr) + i;
        if (c >= N_CH) c = c - N_CH;
        if (in_valid[c]) begin
          grant    = '0;
          grant[c] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = SEL_W'(c);
        end
      end
    end
  end

  // Data of the granted channel.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) gnt_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Ready depends only on grant and output space, never on out_valid loops.
  always_comb begin
    load_en  = ~out_valid | out_ready;
    in_ready = rst_n ? (grant & {N_CH{load_en}}) : '0;
    xfer     = gnt_any & load_en & rst_n;
  end

  // Output register: load on transfer, drop valid on drain only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // RR pointer advances past the winner on round-robin transfers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && mode) begin
      rr_ptr <= (gnt_idx == SEL_W'(N_CH - 1)) ? '0
              : gnt_idx + SEL_W'(1);
    end
  end

  // A held beat stays put until the consumer takes it.
  a_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=>
      out_valid && $stable(out_data) && $stable(out_ch)
  );

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Scoreboard bench for mux_nx1_stream (N_CH=4 main, N_CH=3 for out-of-range sel).
// Reference grant model uses modulo search over a queue of expected beats.
module tb_mux_nx1_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        m3;
  logic [1:0]  s3;
  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  r3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  oc3;
  logic        ordy3;

  always #5 clk = ~clk;

  mux_nx1_stream #(.N_CH(4), .WIDTH(8)) u4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  mux_nx1_stream #(.N_CH(3), .WIDTH(8)) u3 (
    .clk(clk), .rst_n(rst_n), .mode(m3), .sel(s3),
    .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_ch(oc3),
    .out_ready(ordy3)
  );

  typedef struct {
    int ch;
    int d;
  } beat_t;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    active = 1'b0;
  bit    m_ov   = 1'b0;
  int    m_rr   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int ref_grant(input logic md, input int s,
                                   input logic [3:0] v, input int ptr);
    if (!md) return (s < 4 && v[s]) ? s : -1;
    for (int i = 0; i < 4; i++)
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  // Reference model: predicts in_ready/out_valid, queues expected beats.
  initial forever begin
    int    g;
    bit    le;
    int    exp_rdy;
    beat_t b;
    @(negedge clk);
    #3;
    if (active) begin
      g  = ref_grant(mode, int'(sel), in_valid, m_rr);
      le = !m_ov || out_ready;
      exp_rdy = (le && g >= 0) ? (1 << g) : 0;
      chk("in_ready", int'(in_ready), exp_rdy);
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (le && g >= 0) begin
        b.ch = g;
        b.d  = int'(in_data[g*8 +: 8]);
        q.push_back(b);
        if (mode) m_rr = (g + 1) % 4;
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: every accepted output beat is checked against the queue.
  initial forever begin
    beat_t b;
    @(negedge clk);
    #3;
    if (active && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        b = q.pop_front();
        chk("out_ch", int'(out_ch), b.ch);
        chk("out_data", int'(out_data), b.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0; sel = 2'd0; in_valid = 4'hf; in_data = 32'h0;
    out_ready = 1'b0;
    m3 = 1'b0; s3 = 2'd0; v3 = 3'b0; d3 = 24'h0; ordy3 = 1'b1;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    step();
    rst_n = 1'b1;
    active = 1'b1;

    // fixed select, ch2
    mode = 1'b0; sel = 2'd2; in_valid = 4'hf;
    in_data = 32'h13121110; out_ready = 1'b1;
    repeat (8) step();

    // round-robin, all valid
    mode = 1'b1;
    repeat (12) step();

    // skip + wrap: land rr on 3, then ch1, then ch0
    in_valid = 4'b0000; step();
    in_valid = 4'b0100; step();
    in_valid = 4'b0010; step();
    in_valid = 4'b0001; step();
    in_valid = 4'b0000; step();

    // backpressure after a ch1 beat
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    in_data = 32'h44332211;
    step();
    out_ready = 1'b0; in_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();

    // reset while a beat is held
    out_ready = 1'b0;
    repeat (2) step();
    active = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_ch", int'(out_ch), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    q.delete();
    m_ov = 1'b0;
    m_rr = 0;
    step();
    rst_n = 1'b1;
    active = 1'b1;
    mode = 1'b1; in_valid = 4'hf; out_ready = 1'b1;
    repeat (6) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) mode = ~mode;
      sel = 2'($urandom_range(3));
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(9) < 7);
      step();
    end
    in_valid = 4'b0; out_ready = 1'b1;
    repeat (3) step();
    active = 1'b0;
    chk("queue_empty", q.size(), 0);

    // out-of-range sel on the 3-channel build
    m3 = 1'b0; s3 = 2'd0; v3 = 3'b111;
    d3 = 24'h222120; ordy3 = 1'b0;
    #1;
    chk("n3_in_ready_sel0", int'(r3), 1);
    step();
    chk("n3_out_valid", int'(ov3), 1);
    chk("n3_out_data", int'(od3), 8'h20);
    s3 = 2'd3; ordy3 = 1'b1;
    #1;
    chk("n3_in_ready_oor", int'(r3), 0);
    step();
    chk("n3_drained", int'(ov3), 0);
    chk("n3_hold_data", int'(od3), 8'h20);
    chk("n3_hold_ch", int'(oc3), 0);
    #1;
    chk("n3_in_ready_idle", int'(r3), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
